// File: rtl/rv_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// whichever side was not granted last. The history bit moves only on an advanced grant.
module rv_rr_arb2 (
    input  logic       sclk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    logic last_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_b ? 2'b01 : 2'b10;
        end
    end

    // Resetting to "B granted last" gives A the first tie.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (adv && (grant != 2'b00)) begin
            last_b <= grant[1];
        end
    end

endmodule

// File: rtl/rv_sram_arb.sv
// Shares one 1W/1R SRAM between a fetch requester (A) and a load/store requester (B).
// Each SRAM port has its own round-robin arbiter. Read data comes back on one tagged response channel.
module rv_sram_arb #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          sclk,
    input  logic          rst,
    input  logic          a_wr_valid,
    output logic          a_wr_ready,
    input  logic [AW-1:0] a_wr_addr,
    input  logic [DW-1:0] a_wr_data,
    input  logic          b_wr_valid,
    output logic          b_wr_ready,
    input  logic [AW-1:0] b_wr_addr,
    input  logic [DW-1:0] b_wr_data,
    input  logic          a_rd_valid,
    output logic          a_rd_ready,
    input  logic [AW-1:0] a_rd_addr,
    input  logic          b_rd_valid,
    output logic          b_rd_ready,
    input  logic [AW-1:0] b_rd_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          sram_wr_en,
    output logic [AW-1:0] sram_wr_addr,
    output logic [DW-1:0] sram_wr_data,
    output logic          sram_rd_en,
    output logic [AW-1:0] sram_rd_addr,
    input  logic [DW-1:0] sram_rd_data
);

    localparam logic RSP_ID_A = 1'b0;
    localparam logic RSP_ID_B = 1'b1;

    logic [1:0]    wr_grant;
    logic [1:0]    rd_grant;
    logic          rd_can;
    logic          wr_go;
    logic          rd_go;
    logic          collide;
    logic          byp_hit;
    logic [DW-1:0] byp_data;

    rv_rr_arb2 u_wr_arb (
        .sclk  (sclk),
        .rst   (rst),
        .req   ({b_wr_valid, a_wr_valid}),
        .adv   (1'b1),
        .grant (wr_grant)
    );

    // A held response stalls the read port, so SRAM read data stays frozen under it.
    assign rd_can = !rsp_valid || rsp_ready;

    rv_rr_arb2 u_rd_arb (
        .sclk  (sclk),
        .rst   (rst),
        .req   ({b_rd_valid, a_rd_valid} & {2{rd_can}}),
        .adv   (1'b1),
        .grant (rd_grant)
    );

    assign wr_go        = (wr_grant != 2'b00) && !rst;
    assign rd_go        = (rd_grant != 2'b00) && !rst;
    assign a_wr_ready   = wr_grant[0] && !rst;
    assign b_wr_ready   = wr_grant[1] && !rst;
    assign a_rd_ready   = rd_grant[0] && !rst;
    assign b_rd_ready   = rd_grant[1] && !rst;
    assign sram_wr_en   = wr_go;
    assign sram_wr_addr = wr_grant[1] ? b_wr_addr : a_wr_addr;
    assign sram_wr_data = wr_grant[1] ? b_wr_data : a_wr_data;
    assign sram_rd_en   = rd_go;
    assign sram_rd_addr = rd_grant[1] ? b_rd_addr : a_rd_addr;

    // The SRAM returns pre-write data on a same-address collision, so keep the new word here.
    assign collide  = rd_go && wr_go && (sram_rd_addr == sram_wr_addr);
    assign rsp_data = byp_hit ? byp_data : sram_rd_data;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= RSP_ID_A;
            byp_hit   <= 1'b0;
            byp_data  <= '0;
        end else if (rd_go) begin
            rsp_valid <= 1'b1;
            rsp_id    <= rd_grant[1] ? RSP_ID_B : RSP_ID_A;
            byp_hit   <= collide;
            if (collide) begin
                byp_data <= sram_wr_data;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_sram_arb.sv
// Scoreboard bench for rv_sram_arb: a reference model predicts grants and read results.
// A separate monitor compares every presented response against the expected queue.
module tb_rv_sram_arb;

    localparam int DW = 32;
    localparam int AW = 6;

    logic          sclk = 1'b0;
    logic          rst  = 1'b1;
    logic          a_wr_valid = 1'b0, b_wr_valid = 1'b0;
    logic          a_wr_ready, b_wr_ready;
    logic [AW-1:0] a_wr_addr = '0, b_wr_addr = '0;
    logic [DW-1:0] a_wr_data = '0, b_wr_data = '0;
    logic          a_rd_valid = 1'b0, b_rd_valid = 1'b0;
    logic          a_rd_ready, b_rd_ready;
    logic [AW-1:0] a_rd_addr = '0, b_rd_addr = '0;
    logic          rsp_valid, rsp_id;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data;
    logic          sram_wr_en, sram_rd_en;
    logic [AW-1:0] sram_wr_addr, sram_rd_addr;
    logic [DW-1:0] sram_wr_data;
    logic [DW-1:0] sram_rd_data = '0;

    rv_sram_arb #(.DW(DW), .AW(AW)) dut (
        .sclk(sclk), .rst(rst),
        .a_wr_valid(a_wr_valid), .a_wr_ready(a_wr_ready), .a_wr_addr(a_wr_addr), .a_wr_data(a_wr_data),
        .b_wr_valid(b_wr_valid), .b_wr_ready(b_wr_ready), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
        .a_rd_valid(a_rd_valid), .a_rd_ready(a_rd_ready), .a_rd_addr(a_rd_addr),
        .b_rd_valid(b_rd_valid), .b_rd_ready(b_rd_ready), .b_rd_addr(b_rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
    );

    always #5 sclk = ~sclk;

    // External SRAM: registered read that returns pre-write data and holds while rd_en is low.
    logic [DW-1:0] mem [2**AW];
    always @(posedge sclk) begin
        if (sram_wr_en) mem[sram_wr_addr] <= sram_wr_data;
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
    end

    typedef struct { logic id; logic [DW-1:0] data; } rsp_t;
    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [2**AW];
    bit            wr_last_b = 1'b1, rd_last_b = 1'b1, busy = 1'b0, done = 1'b0;
    int            n_vec = 0, n_err = 0;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    // Round-robin rule: 0 = no grant, 1 = A, 2 = B.
    function automatic int rr_pick(input bit a, input bit b, input bit last_b);
        if (a && b) return last_b ? 1 : 2;
        if (a) return 1;
        if (b) return 2;
        return 0;
    endfunction

    task automatic cyc(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                       input bit arv, input logic [AW-1:0] ara,
                       input bit brv, input logic [AW-1:0] bra,
                       input bit rr, output int wg);
        int rg;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] wdata;
        rsp_t e;
        @(negedge sclk);
        a_wr_valid = av;  a_wr_addr = aa; a_wr_data = ad;
        b_wr_valid = bv;  b_wr_addr = ba; b_wr_data = bd;
        a_rd_valid = arv; a_rd_addr = ara;
        b_rd_valid = brv; b_rd_addr = bra;
        rsp_ready = rr;
        #1;
        wg = rr_pick(av, bv, wr_last_b);
        rg = (!busy || rr) ? rr_pick(arv, brv, rd_last_b) : 0;
        waddr = (wg == 2) ? ba : aa;
        wdata = (wg == 2) ? bd : ad;
        raddr = (rg == 2) ? bra : ara;
        chk("a_wr_ready", a_wr_ready, (wg == 1));
        chk("b_wr_ready", b_wr_ready, (wg == 2));
        chk("a_rd_ready", a_rd_ready, (rg == 1));
        chk("b_rd_ready", b_rd_ready, (rg == 2));
        chk("sram_rd_en", sram_rd_en, (rg != 0));
        chk("sram_wr_en", sram_wr_en, (wg != 0));
        if (wg != 0) begin
            chk("sram_wr_addr", sram_wr_addr, waddr);
            chk("sram_wr_data", sram_wr_data, wdata);
        end
        if (rg != 0) begin
            chk("sram_rd_addr", sram_rd_addr, raddr);
            e.id   = (rg == 2);
            e.data = (wg != 0 && waddr == raddr) ? wdata : ref_mem[raddr];
        end
        @(posedge sclk);
        #1;
        if (wg != 0) begin
            ref_mem[waddr] = wdata;
            wr_last_b = (wg == 2);
        end
        if (rg != 0) begin
            exp_q.push_back(e);
            rd_last_b = (rg == 2);
            busy = 1'b1;
        end else if (rr) begin
            busy = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        int wg;
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 0, '0, 0, '0, 1, wg);
    endtask

    // Monitor: the expected queue head is the response the DUT should present right now.
    initial begin
        rsp_t h;
        forever begin
            @(negedge sclk);
            #2;
            if (!rst && !done) begin
                chk("rsp_valid", rsp_valid, (exp_q.size() != 0));
                if (rsp_valid && exp_q.size() != 0) begin
                    h = exp_q[0];
                    chk("rsp_id", rsp_id, h.id);
                    chk("rsp_data", rsp_data, h.data);
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int wg, ai, bi;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        mem[5] = 32'hCAFE0005; ref_mem[5] = 32'hCAFE0005;
        mem[6] = 32'hCAFE0006; ref_mem[6] = 32'hCAFE0006;

        // Reset state, with every request asserted.
        a_wr_valid = 1; b_wr_valid = 1; a_rd_valid = 1; b_rd_valid = 1;
        #3;
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset wr_ready", {a_wr_ready, b_wr_ready}, 0);
        chk("reset rd_ready", {a_rd_ready, b_rd_ready}, 0);
        chk("reset sram_en", {sram_wr_en, sram_rd_en}, 0);
        a_wr_valid = 0; b_wr_valid = 0; a_rd_valid = 0; b_rd_valid = 0;
        @(negedge sclk);
        @(negedge sclk);
        rst = 0;

        // Persistent write contention: A addr 1..4, B addr 9..12, grants alternate.
        ai = 0; bi = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, AW'(1 + ai), DW'(32'hA0 + ai), 1, AW'(9 + bi), DW'(32'hB0 + bi), 0, '0, 0, '0, 1, wg);
            chk("alt wr grant", wg, (i % 2 == 0) ? 1 : 2);
            if (wg == 1) ai++;
            if (wg == 2) bi++;
        end

        // Back-to-back reads: A addr 5, then B addr 6.
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd5, 0, '0, 1, wg);
        cyc(0, '0, '0, 0, '0, '0, 0, '0, 1, 6'd6, 1, wg);
        idle(2);

        // Same-cycle write/read collision at addr 7.
        cyc(0, '0, '0, 1, 6'd7, 32'h12345678, 1, 6'd7, 0, '0, 1, wg);
        idle(2);

        // Stall: held response unaffected by a write to the same address.
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd8, 0, '0, 1, wg);
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd8, 1, 6'd9, 0, wg);
        cyc(1, 6'd8, 32'hFFFF, 0, '0, '0, 1, 6'd8, 1, 6'd9, 0, wg);
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd8, 1, 6'd9, 0, wg);
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd8, 1, 6'd9, 1, wg);
        idle(3);

        // Reset while a response is pending.
        cyc(0, '0, '0, 0, '0, '0, 1, 6'd5, 0, '0, 0, wg);
        @(negedge sclk);
        rst = 1;
        #1;
        chk("mid-reset rsp_valid", rsp_valid, 0);
        exp_q.delete();
        busy = 0; wr_last_b = 1; rd_last_b = 1;
        @(negedge sclk);
        rst = 0;
        a_rd_valid = 0;
        cyc(1, 6'd20, 32'hAAAA0020, 1, 6'd21, 32'hBBBB0021, 1, 6'd20, 1, 6'd21, 1, wg);
        chk("post-reset wr grant A", wg, 1);
        idle(2);

        // Random traffic over a narrow address range so collisions occur often.
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), AW'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                $urandom_range(0, 1), AW'($urandom_range(0, 7)),
                ($urandom_range(0, 3) != 0), wg);
        end
        idle(4);
        chk("drained queue", exp_q.size(), 0);
        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_sram_arb.md
Name: rv_sram_arb

Overview:
- Two-requester arbiter that shares one two-port SRAM (1 write port, 1 registered read port, 1-cycle read latency, read data held while rd_en low) between requester A (fetch side) and requester B (load/store side).
- Arbitrates the write port and the read port independently with round-robin.
- Returns read data on a single tagged, back-pressurable response channel.
- Forwards same-cycle write data to a colliding read, so reads always see the newest value.

Parameters:
- DW, 32, data width.
- AW, 6, address width; SRAM depth is 2**AW.

Ports:
- sclk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- a_wr_valid / b_wr_valid  in  1  write request.
- a_wr_ready / b_wr_ready  out  1  write grant; transfer when valid&&ready.
- a_wr_addr / b_wr_addr  in  AW  write address.
- a_wr_data / b_wr_data  in  DW  write data.
- a_rd_valid / b_rd_valid  in  1  read request.
- a_rd_ready / b_rd_ready  out  1  read grant.
- a_rd_addr / b_rd_addr  in  AW  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response accepted.
- rsp_id  out  1  0 = A, 1 = B.
- rsp_data  out  DW  read data.
- sram_wr_en  out  1  to SRAM.
- sram_wr_addr  out  AW  to SRAM.
- sram_wr_data  out  DW  to SRAM.
- sram_rd_en  out  1  to SRAM.
- sram_rd_addr  out  AW  to SRAM.
- sram_rd_data  in  DW  from SRAM; valid the cycle after sram_rd_en.

Behaviour:
- Reset (async, rst=1):
  - rsp_valid=0, rsp_id=0.
  - Bypass flag=0, bypass data=0.
  - Write and read RR pointers = "last granted B", so A wins first.
  - All ready and sram enable outputs are combinational and read 0 while in reset.
- Write arbitration (combinational, zero latency):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not granted last; wr pointer updates only on a granted write.
  - sram_wr_en = a_wr_valid|b_wr_valid; sram_wr_addr/data are muxed from the winner.
  - Never more than one wr_ready high.
- Read issue condition: rd_can = !rsp_valid || rsp_ready.
  - Read arbitration uses the same RR rule with its own pointer, gated by rd_can.
  - sram_rd_en = rd_can && (a_rd_valid|b_rd_valid).
  - Grant is the winner's rd_ready. rd_ready is 0 for both while rd_can=0.
- Response, registered, latency 1:
  - On issue, rsp_valid<=1 and rsp_id<=winner next cycle.
  - With rsp_valid&&rsp_ready and no new issue, rsp_valid<=0.
  - With rsp_valid&&rsp_ready and a new issue, rsp_valid stays 1 with the new id and data: back-to-back, 1 read per cycle.
- Stall: while rsp_valid && !rsp_ready, sram_rd_en=0.
  - SRAM rd_data holds, so rsp_data/rsp_id stay stable until accepted.
  - Later writes do not alter the held response.
- Write-read collision: read issued and write granted in the same cycle with sram_rd_addr == sram_wr_addr.
  - SRAM returns old data, so the arbiter registers byp_hit<=1 and byp_data<=sram_wr_data.
  - rsp_data = byp_hit ? byp_data : sram_rd_data.
  - byp_hit reloads on every read issue (0 when no collision) and holds during a stall.
- Read and write from the same requester in the same cycle are allowed; the ports are independent.
- A write to an address being read in a later cycle needs no special handling; SRAM ordering suffices.
- Reset asserted mid-response drops the response with no replay. SRAM contents are not cleared.
- Address wrap: none. Addresses are AW bits and all 2**AW entries are valid.

Decomposition:
- No shared package needed; rsp_id encoding (A=0, B=1) is a localparam.
- One natural sub-module, rv_rr_arb2: a 2-way round-robin arbiter (req[1:0], advance enable, grant[1:0], last-grant flop, async active-high reset).
  - Instantiated twice, once for write and once for read.
- The SRAM instance stays outside this block; the top level wires the two together.

Test Plan:
- Both write every cycle for 4 cycles, A addr 1..4, B addr 9..12 -> grants alternate A,B,A,B. SRAM writes addr 1, 9, 2, 10; A and B each stall one cycle per grant.
- A reads addr 5 (preloaded 0xCAFE0005) with rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xCAFE0005. Same cycle, B read addr 6 issues back-to-back; response follows in the next cycle.
- B writes 0x12345678 to addr 7 while A reads addr 7 in the same cycle (old value 0) -> response rsp_id=0, rsp_data=0x12345678.
- Response stall: rsp_ready=0 for 3 cycles with both rd_valid high -> rd_ready both 0 and sram_rd_en=0. A write of 0xFFFF to the read address changes nothing: rsp_data holds. On rsp_ready=1, the next read issues the same cycle.
- Assert rst while rsp_valid=1 -> rsp_valid=0 immediately. After release, simultaneous A/B write and read requests grant A first on both ports.
- Random A/B traffic, 2000 cycles, against a reference memory model -> every response matches the model value at the issue cycle with forwarding applied. No double grants.
